fifo_param: RTL and testbench

Parametrised synchronous FIFO, successor to the fixed 8-bit × 16-entry FIFO. Adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and one-cycle overflow/underflow error pulses. Optional first-word-fall-through read mode is selected at compile time. Single clock domain; used as the general-purpose buffer between producer/consumer blocks.

---
 rtl/fifo_param.sv | 78 +++++++
 tb/tb_fifo_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and overflow/underflow pulses; FIFO_FWFT_EN selects first-word-fall-through reads.
// Flags and count update on the accepting edge; writes while full and reads while empty are dropped and flagged.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered count, so there is no input-to-flag path.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= write_en && full;
            underflow <= read_en && empty;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Randomised scoreboard bench for fifo_param: a queue-based reference model predicts state each edge; a negedge monitor compares.
module tb_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
        int dout;
    } stat_t;

    int    model_q[$];
    int    exp_data[$];
    stat_t exp_stat[$];
    int    last_out = 0;
    int    errors = 0;
    int    checks = 0;
    stat_t mon_s;
    bit    rd_fire = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle and advances the reference model across the edge.
    task automatic step(input bit we, input bit re, input int din);
        stat_t s;
        bit    wr_ok, rd_ok;
        int    n;
        write_en = we;
        read_en  = re;
        data_in  = din[DW-1:0];
        @(posedge clk);
        n     = model_q.size();
        wr_ok = we && (n < DEPTH);
        rd_ok = re && (n > 0);
        s.ovf = we && (n == DEPTH);
        s.unf = re && (n == 0);
        if (rd_ok) begin
            last_out = model_q.pop_front();
            exp_data.push_back(last_out);
        end
        if (wr_ok) model_q.push_back(din & 'hFF);
        s.cnt = model_q.size();
`ifdef FIFO_FWFT_EN
        s.dout = (model_q.size() > 0) ? model_q[0] : 0;
`else
        s.dout = last_out;
`endif
        exp_stat.push_back(s);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_unf"}, underflow, 0);
    endtask

    task automatic fill_to(input int n);
        while (model_q.size() < n) step(1'b1, 1'b0, $urandom_range(0, 255));
    endtask

    task automatic drain_to(input int n);
        while (model_q.size() > n) step(1'b0, 1'b1, 0);
    endtask

    always @(posedge clk) rd_fire <= read_en && !empty;

    always @(negedge clk) begin
        if (exp_stat.size() > 0) begin
            mon_s = exp_stat.pop_front();
            chk("count", count, mon_s.cnt);
            chk("full", full, mon_s.cnt == DEPTH);
            chk("empty", empty, mon_s.cnt == 0);
            chk("almost_full", almost_full, mon_s.cnt >= AF);
            chk("almost_empty", almost_empty, mon_s.cnt <= AE);
            chk("overflow", overflow, mon_s.ovf);
            chk("underflow", underflow, mon_s.unf);
            chk("data_out", data_out, mon_s.dout);
        end
`ifndef FIFO_FWFT_EN
        if (rd_fire && rst) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_word: DUT popped a word, scoreboard had none");
            end else begin
                chk("read_word", data_out, exp_data.pop_front());
            end
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check_reset_state("reset");
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill, overflow, then drain and underflow.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, i);
        step(1'b1, 1'b0, 'hFF);
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $urandom_range(0, 255));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 'hA0 + i);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0);

        // Simultaneous traffic at steady occupancy, at full and at empty.
        fill_to(5);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, $urandom_range(0, 255));
        fill_to(DEPTH);
        step(1'b1, 1'b1, 'h77);
        step(1'b0, 1'b0, 0);
        drain_to(0);
        step(1'b1, 1'b1, 'h66);
        step(1'b0, 1'b0, 0);

        // Random phases: write-biased then read-biased to visit both boundaries.
        for (int i = 0; i < 400; i++) begin
            if (i < 200) step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, $urandom_range(0, 255));
            else         step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, $urandom_range(0, 255));
        end
        drain_to(0);

        // Asynchronous reset mid-stream, away from any clock edge.
        fill_to(7);
        #1 rst = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        model_q.delete();
        exp_stat.delete();
        exp_data.delete();
        last_out = 0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 'h55);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);

        // Single word shown without a read in FWFT builds, registered on read otherwise.
        step(1'b1, 1'b0, 'h3C);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_stat.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
